// File: rtl/jtag_tap_driver.sv
// JTAG initiator: turns TAP reset / IR scan / DR scan / idle-clock commands into
// TCK/TMS/TDI waveforms with a divided TCK and returns the captured TDO bits.
module jtag_tap_driver #(
    parameter int MAX_LEN = 64,
    parameter int CLK_DIV = 4,
    parameter int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [1:0]         cmd_op_i,
    input  logic [LW-1:0]      cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_data_o,
    output logic               rsp_err_o,
    output logic               busy_o,
    output logic               jtag_tck_o,
    output logic               jtag_tms_o,
    output logic               jtag_tdi_o,
    output logic               jtag_trst_no,
    input  logic               jtag_tdo_i
);

    // state  | meaning
    // S_IDLE | waiting for a command, cmd_ready_o high
    // S_RUN  | generating TCK periods for the latched command
    // S_RESP | response presented, waiting for rsp_ready_i
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;

    localparam int TW = $clog2(MAX_LEN + 7);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [LW-1:0]      len_q;
    logic [MAX_LEN-1:0] data_q;
    logic [TW-1:0]      n_tck_q;
    logic [TW-1:0]      tck_cnt;
    logic [DW-1:0]      div_cnt;
    logic               tap_known;

    function automatic logic [TW-1:0] pre_cnt(input logic [1:0] op);
        logic [TW-1:0] r;
        case (op)
            OP_IR:   r = TW'(4);
            OP_DR:   r = TW'(3);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic in_shift(input logic [1:0] op, input logic [TW-1:0] len,
                                      input logic [TW-1:0] k);
        return (op == OP_IR || op == OP_DR) && (k >= pre_cnt(op)) && (k < pre_cnt(op) + len);
    endfunction

    function automatic logic tms_at(input logic [1:0] op, input logic [TW-1:0] len,
                                    input logic [TW-1:0] k);
        logic          r;
        logic [TW-1:0] pre;
        pre = pre_cnt(op);
        case (op)
            OP_RESET: r = (k < TW'(5));
            OP_IDLE:  r = 1'b0;
            default: begin
                if (k < pre)
                    r = (op == OP_IR) ? (k < TW'(2)) : (k == '0);
                else if (k + TW'(1) < pre + len)
                    r = 1'b0;
                else
                    r = (k <= pre + len);
            end
        endcase
        return r;
    endfunction

    logic [LW-1:0]      len_clamp;
    logic               reject;
    logic [TW-1:0]      n_tck_in;
    logic [1:0]         sel_op;
    logic [TW-1:0]      sel_len;
    logic [TW-1:0]      sel_k;
    logic [MAX_LEN-1:0] sel_data_sh;
    logic               drv_tms;
    logic               drv_tdi;
    logic               drv_trst_n;
    logic               smp_shift;
    logic [TW-1:0]      smp_idx;

    always_comb begin
        len_clamp = (cmd_len_i > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len_i;
        reject    = (cmd_op_i == OP_IR || cmd_op_i == OP_DR) && !tap_known;
        n_tck_in  = '0;
        case (cmd_op_i)
            OP_RESET: n_tck_in = TW'(6);
            OP_IR:    if (len_clamp != '0) n_tck_in = TW'(len_clamp) + TW'(6);
            OP_DR:    if (len_clamp != '0) n_tck_in = TW'(len_clamp) + TW'(5);
            default:  n_tck_in = TW'(len_clamp);
        endcase
        if (reject) n_tck_in = '0;

        // In IDLE the first TCK's pins come straight from the command inputs.
        if (state == S_IDLE) begin
            sel_op      = cmd_op_i;
            sel_len     = TW'(len_clamp);
            sel_k       = '0;
            sel_data_sh = cmd_data_i;
        end else begin
            sel_op      = op_q;
            sel_len     = TW'(len_q);
            sel_k       = tck_cnt + TW'(1);
            sel_data_sh = data_q >> (sel_k - pre_cnt(op_q));
        end
        drv_tms    = tms_at(sel_op, sel_len, sel_k);
        drv_tdi    = in_shift(sel_op, sel_len, sel_k) ? sel_data_sh[0] : 1'b0;
        drv_trst_n = !((sel_op == OP_RESET) && (sel_k < TW'(5)));
        smp_shift  = in_shift(op_q, TW'(len_q), tck_cnt);
        smp_idx    = tck_cnt - pre_cnt(op_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            op_q         <= OP_RESET;
            len_q        <= '0;
            data_q       <= '0;
            n_tck_q      <= '0;
            tck_cnt      <= '0;
            div_cnt      <= '0;
            tap_known    <= 1'b0;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_data_o   <= '0;
            rsp_err_o    <= 1'b0;
            busy_o       <= 1'b0;
            jtag_tck_o   <= 1'b0;
            jtag_tms_o   <= 1'b1;
            jtag_tdi_o   <= 1'b0;
            jtag_trst_no <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    jtag_trst_no <= 1'b1;
                    if (cmd_valid_i) begin
                        op_q        <= cmd_op_i;
                        len_q       <= len_clamp;
                        data_q      <= cmd_data_i;
                        n_tck_q     <= n_tck_in;
                        tck_cnt     <= '0;
                        div_cnt     <= DW'(CLK_DIV - 1);
                        rsp_data_o  <= '0;
                        rsp_err_o   <= reject;
                        cmd_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= S_RUN;
                        if (n_tck_in != '0) begin
                            jtag_tms_o   <= drv_tms;
                            jtag_tdi_o   <= drv_tdi;
                            jtag_trst_no <= drv_trst_n;
                        end
                    end
                end
                S_RUN: begin
                    if (n_tck_q == '0) begin
                        rsp_valid_o <= 1'b1;
                        state       <= S_RESP;
                    end else if (div_cnt != '0) begin
                        div_cnt <= div_cnt - DW'(1);
                    end else begin
                        div_cnt <= DW'(CLK_DIV - 1);
                        if (!jtag_tck_o) begin
                            jtag_tck_o <= 1'b1;
                            if (smp_shift)
                                rsp_data_o <= rsp_data_o | (MAX_LEN'(jtag_tdo_i) << smp_idx);
                        end else begin
                            jtag_tck_o <= 1'b0;
                            if (tck_cnt == n_tck_q - TW'(1)) begin
                                rsp_valid_o <= 1'b1;
                                jtag_tdi_o  <= 1'b0;
                                state       <= S_RESP;
                                if (op_q == OP_RESET) tap_known <= 1'b1;
                            end else begin
                                tck_cnt      <= tck_cnt + TW'(1);
                                jtag_tms_o   <= drv_tms;
                                jtag_tdi_o   <= drv_tdi;
                                jtag_trst_no <= drv_trst_n;
                            end
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/jtag_tap_driver.md
# jtag_tap_driver

JTAG initiator that drives the SoC debug TAP (`jtag_tck/tms/tdi/trst`, returning `tdo`) from a simple command/response interface, so a host-side or on-FPGA sequencer can issue TAP reset, IR scan, DR scan and idle-clock commands without bit-banging. It sits on the FPGA board wrapper side, feeding the MCU's JTAG target pins, and runs from one fabric clock with TCK derived by an internal divider.

## Interface
- `MAX_LEN`, 64, maximum scan length in bits; width of data buses.
- `CLK_DIV`, 4, `clk_i` cycles per TCK half-period (>=1).
- `LW`, `$clog2(MAX_LEN+1)`, width of length field (derived).

Ports:
- `clk_i` input 1 fabric clock; one clock domain.
- `rst_ni` input 1 reset; asynchronous, active-low.
- `cmd_valid_i` input 1 command valid.
- `cmd_ready_o` output 1 command accepted when both high.
- `cmd_op_i` input 2 00 TAP_RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE.
- `cmd_len_i` input LW bit count (shift ops) or TCK count (IDLE); ignored for TAP_RESET.
- `cmd_data_i` input MAX_LEN TDI data, LSB shifted first.
- `rsp_valid_o` output 1 response valid.
- `rsp_ready_i` input 1 response consumed when both high.
- `rsp_data_o` output MAX_LEN captured TDO, bit i = i-th shifted bit; bits >= len are 0.
- `rsp_err_o` output 1 command rejected (TAP state unknown).
- `busy_o` output 1 high from acceptance until response handshake.
- `jtag_tck_o`, `jtag_tms_o`, `jtag_tdi_o`, `jtag_trst_no` output 1 each; to target.
- `jtag_tdo_i` input 1 from target.

## Operation
- States: IDLE, RUN, RESP. IDLE: `cmd_ready_o`=1. Accept -> RUN (or straight to RESP if zero TCKs). RUN ends after last TCK -> RESP. RESP holds `rsp_*` stable until `rsp_ready_i` -> IDLE.
- TMS sequences (TAP assumed in Run-Test/Idle between commands):
  - TAP_RESET: TMS 1,1,1,1,1,0 (6 TCKs); `jtag_trst_no`=0 during first 5 TCKs; sets `tap_known`.
  - SHIFT_IR: 1,1,0,0, then len shift bits (TMS 0, last bit 1), then 1,0. Total len+6 TCKs.
  - SHIFT_DR: 1,0,0, then len shift bits (last TMS 1), then 1,0. Total len+5 TCKs.
  - IDLE: TMS 0 for len TCKs.
- TDI = `cmd_data_i[i]` during shift bit i, 0 otherwise. TDO sampled only during shift bits.
- `cmd_len_i` > MAX_LEN clamps to MAX_LEN. Shift op with len 0: no TCKs, `rsp_data_o`=0, `rsp_err_o`=0. IDLE len 0: no TCKs.
- `tap_known` cleared by `rst_ni`; SHIFT_IR/SHIFT_DR while clear -> no TCKs, response with `rsp_err_o`=1, data 0. IDLE and TAP_RESET always allowed.
- Command data latched at acceptance; input changes afterwards ignored.

## Timing
- Reset values: `cmd_ready_o`=1, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0, `busy_o`=0, `jtag_tck_o`=0, `jtag_tms_o`=1, `jtag_tdi_o`=0, `jtag_trst_no`=0 (goes 1 on first `clk_i` edge after `rst_ni` release).
- All outputs registered. Acceptance edge = cycle 0. For TCK k (0-based): TMS/TDI update at cycle 2*CLK_DIV*k (TCK low), TCK rises at 2*CLK_DIV*k+CLK_DIV; `jtag_tdo_i` sampled on that same rising edge.
- N-TCK command: `rsp_valid_o` rises at cycle 2*CLK_DIV*N with TCK low. Zero-TCK command: `rsp_valid_o` at cycle 1.
- Response handshake edge returns to IDLE; next command can be accepted the following cycle. No back-to-back overlap.
- `rst_ni` assertion mid-command: all outputs to reset values asynchronously, command and response discarded, `tap_known` cleared.
- Width: TCK counter covers MAX_LEN+6; divider counter ceil(log2(CLK_DIV)) bits; no wrap within a command.

## Test plan
- CLK_DIV=2. After reset, TAP_RESET -> 6 TCKs, TMS 1,1,1,1,1,0, trst_no low for first 5, `rsp_valid_o` at cycle 24, err 0.
- After reset, SHIFT_DR len 32 without TAP_RESET -> no TCK edge, `rsp_valid_o` at cycle 1, `rsp_err_o`=1, data 0.
- TAP model with IR capture 0b00001: TAP_RESET then SHIFT_IR len 5 data 0x1F -> TMS 1,1,0,0,0,0,0,0,1,1,0; TDI 1s during shift; `rsp_data_o`=0x01; model IR=0x1F.
- SHIFT_DR len 32 with IDCODE 0x4BA00477 -> 37 TCKs, `rsp_data_o`=0x4BA00477, bits 63:32 zero; len 80 clamps to 64.
- Hold `rsp_ready_i` low 10 cycles -> `rsp_*` stable, `cmd_ready_o`=0, TCK stays 0; handshake then next command accepted one cycle later.
- Assert `rst_ni` during shift bit 10 -> immediate reset values; subsequent SHIFT_DR returns `rsp_err_o`=1.
